// File: rtl/wfg_wb_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : wfg_wb_interconnect
// Purpose  : Wishbone bus controller between the user-area host port and the
//            wfg subordinates. Decodes the address page, forwards one
//            transaction at a time to the selected subordinate, returns its
//            data/ack, and raises a bus error for unmapped pages or
//            subordinates that do not answer within TIMEOUT cycles. The last
//            failing address and a saturating error count are kept for debug.
// Ports    : wb_clk_i, wb_rst_ni      - bus clock, async active-low reset
//            wbs_*_i / wbs_*_o        - host-side Wishbone slave port
//            sub_*_o / sub_*_i        - fan-out to NSUB subordinates
//            err_adr_o, err_cnt_o     - debug: last error address, count
// Revision : 1.0 - initial release
// ============================================================================
module wfg_wb_interconnect #(
  parameter int BUSW    = 32,
  parameter int NSUB    = 3,
  parameter int TIMEOUT = 15
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [BUSW-1:0]      wbs_adr_i,
  input  logic [BUSW-1:0]      wbs_dat_i,
  output logic [BUSW-1:0]      wbs_dat_o,
  output logic                 wbs_ack_o,
  output logic                 wbs_err_o,
  output logic [NSUB-1:0]      sub_cyc_o,
  output logic [NSUB-1:0]      sub_stb_o,
  output logic                 sub_we_o,
  output logic [3:0]           sub_adr_o,
  output logic [BUSW-1:0]      sub_dat_o,
  input  logic [NSUB*BUSW-1:0] sub_dat_i,
  input  logic [NSUB-1:0]      sub_ack_i,
  output logic [BUSW-1:0]      err_adr_o,
  output logic [7:0]           err_cnt_o
);

  localparam int IW = (NSUB > 1) ? $clog2(NSUB) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam int PW = BUSW - 8;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t            state_q;
  logic [IW-1:0]     idx_q;
  logic [CW-1:0]     tcnt_q;
  logic [BUSW-1:0]   req_adr_q;
  logic [NSUB-1:0]   stb_q;
  logic              we_q;
  logic [3:0]        adr_q;
  logic [BUSW-1:0]   wdat_q;
  logic [BUSW-1:0]   rdat_q;
  logic [BUSW-1:0]   err_adr_q;
  logic [7:0]        err_cnt_q;
  logic              ack_q;
  logic              err_q;

  // ---------------------------------------------------------------------------
  // Address decode: top nibble 0x3 selects the wfg region, the page field
  // (everything between the nibble and the 16-byte register window) picks
  // the subordinate. Page 0 is deliberately left unmapped.
  // ---------------------------------------------------------------------------
  logic [PW-1:0]   req_page;
  logic            req_valid;
  logic            req_mapped;
  logic [IW-1:0]   req_idx;
  logic [NSUB-1:0] req_onehot;

  assign req_page   = wbs_adr_i[BUSW-5:4];
  assign req_valid  = wbs_cyc_i && wbs_stb_i;
  assign req_mapped = (wbs_adr_i[BUSW-1:BUSW-4] == 4'h3) &&
                      (req_page != '0) && (req_page <= PW'(NSUB));
  assign req_idx    = IW'(req_page - PW'(1));

  always_comb begin
    req_onehot = '0;
    for (int i = 0; i < NSUB; i++) begin
      if (req_idx == IW'(i)) req_onehot[i] = 1'b1;
    end
  end

  // Only the selected subordinate's ack/data are visible; others are ignored.
  logic            sel_ack;
  logic [BUSW-1:0] sel_dat;

  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < NSUB; i++) begin
      if (idx_q == IW'(i)) begin
        sel_ack = sub_ack_i[i];
        sel_dat = sub_dat_i[i*BUSW +: BUSW];
      end
    end
  end

  // Error entry: either an unmapped request straight from IDLE (its address
  // is still on the bus) or a timeout in FWD (address taken from the request
  // register). A host abort or an ack in the last cycle both beat the timeout.
  logic            go_err;
  logic [BUSW-1:0] err_src;

  always_comb begin
    go_err  = 1'b0;
    err_src = req_adr_q;
    if (state_q == IDLE && req_valid && !req_mapped) begin
      go_err  = 1'b1;
      err_src = wbs_adr_i;
    end else if (state_q == FWD && wbs_cyc_i && !sel_ack && tcnt_q == TLAST) begin
      go_err  = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tcnt_q    <= '0;
      req_adr_q <= '0;
      stb_q     <= '0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      wdat_q    <= '0;
      rdat_q    <= '0;
      err_adr_q <= '0;
      err_cnt_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            idx_q     <= req_idx;
            we_q      <= wbs_we_i;
            adr_q     <= wbs_adr_i[3:0];
            wdat_q    <= wbs_dat_i;
            req_adr_q <= wbs_adr_i;
            tcnt_q    <= '0;
            if (req_mapped) begin
              stb_q   <= req_onehot;
              state_q <= FWD;
            end else begin
              state_q <= ERR;
            end
          end
        end
        FWD: begin
          if (!wbs_cyc_i) begin
            stb_q   <= '0;
            state_q <= IDLE;
          end else if (sel_ack) begin
            stb_q   <= '0;
            rdat_q  <= sel_dat;
            ack_q   <= 1'b1;
            state_q <= RESP;
          end else if (tcnt_q == TLAST) begin
            stb_q   <= '0;
            state_q <= ERR;
          end else begin
            tcnt_q  <= tcnt_q + CW'(1);
          end
        end
        RESP: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
        ERR: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      // Error bookkeeping lands with the transition so the debug registers
      // are already valid in the cycle wbs_err_o is high.
      if (go_err) begin
        err_q     <= 1'b1;
        err_adr_q <= err_src;
        rdat_q    <= '0;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign wbs_dat_o = rdat_q;
  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign sub_cyc_o = stb_q;
  assign sub_stb_o = stb_q;
  assign sub_we_o  = we_q;
  assign sub_adr_o = adr_q;
  assign sub_dat_o = wdat_q;
  assign err_adr_o = err_adr_q;
  assign err_cnt_o = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wfg_wb_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : tb_wfg_wb_interconnect
// Purpose  : Self-checking bench for wfg_wb_interconnect. Each transaction's
//            expected outcome (ack / error / abort, its cycle, strobe window,
//            returned data, debug registers) is derived from the addressing
//            and timing rules, then compared cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wfg_wb_interconnect;

  localparam int BUSW    = 32;
  localparam int NSUB    = 3;
  localparam int TIMEOUT = 15;
  localparam int K_ACK   = 0;
  localparam int K_ERR   = 1;
  localparam int K_ABT   = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 cyc, stb, we;
  logic [BUSW-1:0]      adr, wdat;
  logic [BUSW-1:0]      dat_o;
  logic                 ack_o, err_o;
  logic [NSUB-1:0]      sub_cyc, sub_stb;
  logic                 sub_we;
  logic [3:0]           sub_adr;
  logic [BUSW-1:0]      sub_wdat;
  logic [NSUB*BUSW-1:0] sub_rdat;
  logic [NSUB-1:0]      sub_ack;
  logic [BUSW-1:0]      err_adr;
  logic [7:0]           err_cnt;

  int ncmp  = 0;
  int nfail = 0;

  // Reference state of the debug/readback registers.
  logic [31:0] m_dat;
  logic [31:0] m_err_adr;
  int          m_err_cnt;

  wfg_wb_interconnect #(.BUSW(BUSW), .NSUB(NSUB), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_dat_o (dat_o),
    .wbs_ack_o (ack_o),
    .wbs_err_o (err_o),
    .sub_cyc_o (sub_cyc),
    .sub_stb_o (sub_stb),
    .sub_we_o  (sub_we),
    .sub_adr_o (sub_adr),
    .sub_dat_o (sub_wdat),
    .sub_dat_i (sub_rdat),
    .sub_ack_i (sub_ack),
    .err_adr_o (err_adr),
    .err_cnt_o (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".dat"},     dat_o, 32'h0);
    chk({tag, ".ack"},     32'(ack_o), 32'h0);
    chk({tag, ".err"},     32'(err_o), 32'h0);
    chk({tag, ".sub_cyc"}, 32'(sub_cyc), 32'h0);
    chk({tag, ".sub_stb"}, 32'(sub_stb), 32'h0);
    chk({tag, ".sub_we"},  32'(sub_we), 32'h0);
    chk({tag, ".sub_adr"}, 32'(sub_adr), 32'h0);
    chk({tag, ".sub_dat"}, sub_wdat, 32'h0);
    chk({tag, ".err_adr"}, err_adr, 32'h0);
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'h0);
  endtask

  // One host transaction. ack_cyc: cycle in which the target subordinate acks
  // (0 or > TIMEOUT = never in time). abort_cyc: cycle during which the host
  // drops cyc (0 = no abort). Cycle n is the one following edge n-1, with
  // the request sampled at edge 0.
  task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [95:0] sd, input int ack_cyc, input int abort_cyc);
    int          page, tgt, kind, resp, stb_last, last_c, new_cnt;
    bit          mapped, seen;
    logic [31:0] new_dat, exp_stb;
    logic [NSUB-1:0] mask;

    page   = int'(a[27:4]);
    mapped = (a[31:28] == 4'h3) && (page >= 1) && (page <= NSUB);
    tgt    = mapped ? page - 1 : 0;
    mask   = mapped ? NSUB'(1 << tgt) : '0;

    if (!mapped) begin
      kind = K_ERR; resp = 1; stb_last = 0;
    end else if (abort_cyc != 0 &&
                 (ack_cyc == 0 || ack_cyc > TIMEOUT || abort_cyc < ack_cyc)) begin
      kind = K_ABT; resp = 0; stb_last = abort_cyc;
    end else if (ack_cyc >= 1 && ack_cyc <= TIMEOUT) begin
      kind = K_ACK; resp = ack_cyc + 1; stb_last = ack_cyc;
    end else begin
      kind = K_ERR; resp = TIMEOUT + 1; stb_last = TIMEOUT;
    end
    last_c  = (kind == K_ABT) ? abort_cyc + 1 : resp + 1;
    new_dat = (kind == K_ACK) ? sd[tgt*32 +: 32] : 32'h0;
    new_cnt = (m_err_cnt == 255) ? 255 : m_err_cnt + 1;

    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    sub_rdat = sd; sub_ack = '0;
    seen = 1'b0;

    for (int c = 1; c <= last_c; c++) begin
      @(posedge clk); #1;
      if (seen || c == abort_cyc) begin
        cyc = 1'b0; stb = 1'b0;
      end
      // Random acks from non-selected subordinates must be ignored.
      sub_ack = NSUB'($urandom) & ~mask;
      if (mapped && c == ack_cyc) sub_ack[tgt] = 1'b1;
      @(negedge clk);
      if (c == 1) begin
        chk("sub_adr", 32'(sub_adr), 32'(a[3:0]));
        chk("sub_we",  32'(sub_we), 32'(w));
        chk("sub_dat", sub_wdat, d);
      end
      exp_stb = (mapped && c <= stb_last) ? (32'd1 << tgt) : 32'd0;
      chk("sub_stb", 32'(sub_stb), exp_stb);
      chk("sub_cyc", 32'(sub_cyc), exp_stb);
      chk("ack", 32'(ack_o), 32'(kind == K_ACK && c == resp));
      chk("err", 32'(err_o), 32'(kind == K_ERR && c == resp));
      chk("dat", dat_o, (kind != K_ABT && c >= resp) ? new_dat : m_dat);
      chk("err_cnt", 32'(err_cnt), (kind == K_ERR && c >= resp) ? 32'(new_cnt) : 32'(m_err_cnt));
      chk("err_adr", err_adr, (kind == K_ERR && c >= resp) ? a : m_err_adr);
      if (ack_o || err_o) seen = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0; sub_ack = '0;

    if (kind != K_ABT) m_dat = new_dat;
    if (kind == K_ERR) begin
      m_err_cnt = new_cnt;
      m_err_adr = a;
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    int sel;
    sel = $urandom_range(0, 5);
    a   = $urandom;
    case (sel)
      0, 1, 2: a = {4'h3, 24'($urandom_range(1, NSUB)), a[3:0]};
      3:       a = {4'h3, 24'h0, a[3:0]};
      4:       a = {4'h3, 24'($urandom_range(NSUB + 1, 255)), a[3:0]};
      default: a = {(a[31:28] == 4'h3) ? 4'h9 : a[31:28], a[27:0]};
    endcase
    return a;
  endfunction

  initial begin
    logic [31:0] a;
    int ak, ab;

    rst_n = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0;
    sub_rdat = '0; sub_ack = '0;
    m_dat = '0; m_err_adr = '0; m_err_cnt = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 chk_all_zero("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("after_reset");

    // Write to subordinate 1, ack in cycle 2
    txn(32'h3000_0024, 1'b1, 32'h0000_1234, {$urandom, $urandom, $urandom}, 2, 0);
    // Read subordinate 0, ack in cycle 1 (minimum latency)
    txn(32'h3000_0010, 1'b0, 32'h0, {64'h0, 32'hA5A5_A5A5}, 1, 0);
    chk("read_data", dat_o, 32'hA5A5_A5A5);
    // Null page, then outside the wfg region
    txn(32'h3000_0000, 1'b0, 32'h0, {$urandom, $urandom, $urandom}, 1, 0);
    txn(32'h4000_0010, 1'b1, 32'h55, {$urandom, $urandom, $urandom}, 1, 0);
    chk("err_cnt_two", 32'(err_cnt), 32'd2);
    chk("err_adr_two", err_adr, 32'h4000_0010);
    // Subordinate 2 never acks -> timeout
    txn(32'h3000_0030, 1'b0, 32'h0, {$urandom, $urandom, $urandom}, 0, 0);
    chk("tmo_err_adr", err_adr, 32'h3000_0030);
    // Ack in the last allowed cycle wins over the timeout
    txn(32'h3000_0030, 1'b0, 32'h0, {$urandom, $urandom, $urandom}, TIMEOUT, 0);
    // Host abort in FWD cycle 3
    txn(32'h3000_0020, 1'b1, 32'hDEAD_BEEF, {$urandom, $urandom, $urandom}, 0, 3);

    // Randomised transactions
    for (int n = 0; n < 40; n++) begin
      a  = rnd_addr();
      ak = $urandom_range(0, TIMEOUT + 2);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TIMEOUT) : 0;
      if (ab == ak) ab = 0;
      txn(a, 1'($urandom), $urandom, {$urandom, $urandom, $urandom}, ak, ab);
    end

    // Error counter saturation
    for (int n = 0; n < 260; n++) begin
      a = $urandom;
      txn({4'h7, a[27:0]}, 1'b0, 32'h0, {$urandom, $urandom, $urandom}, 0, 0);
    end
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);

    // Asynchronous reset in the middle of a forwarded transaction
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0028; wdat = 32'hCAFE_F00D;
    sub_ack = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_stb", 32'(sub_stb), 32'h2);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    m_dat = '0; m_err_adr = '0; m_err_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_ack", 32'(ack_o), 32'h0);
      chk("post_rst_err", 32'(err_o), 32'h0);
      chk("post_rst_stb", 32'(sub_stb), 32'h0);
    end
    // Bus still usable after reset
    txn(32'h3000_0014, 1'b0, 32'h0, {$urandom, $urandom, $urandom}, 4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  // Absolute time guard so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/wfg_wb_interconnect.md
# wfg_wb_interconnect

Wishbone bus controller between the caravel user-area host port and the wfg subordinate blocks (core, sine stimulus, SPI driver). Decodes the address page, forwards one transaction at a time to the selected subordinate, and returns its data and acknowledge to the host. Unmapped pages and unresponsive subordinates get a bus error. The failing address and a saturating error count are kept for debug.

## Interface
- BUSW, 32, host data/address width
- NSUB, 3, number of subordinates; subordinate i occupies page i+1
- TIMEOUT, 15, FWD cycles without subordinate ack before a timeout error (≥2)
- wb_clk_i  in  1  bus clock
- wb_rst_ni  in  1  reset; one clock, asynchronous, active-low
- wbs_cyc_i  in  1  host cycle
- wbs_stb_i  in  1  host strobe
- wbs_we_i  in  1  host write enable
- wbs_adr_i  in  BUSW  host byte address
- wbs_dat_i  in  BUSW  host write data
- wbs_dat_o  out  BUSW  read data, valid with wbs_ack_o
- wbs_ack_o  out  1  transaction done, one-cycle pulse
- wbs_err_o  out  1  transaction failed, one-cycle pulse
- sub_cyc_o  out  NSUB  per-subordinate cycle
- sub_stb_o  out  NSUB  per-subordinate strobe, one-hot or zero
- sub_we_o  out  1  write enable to subordinates
- sub_adr_o  out  4  register offset (wbs_adr_i[3:0])
- sub_dat_o  out  BUSW  write data to subordinates
- sub_dat_i  in  NSUB*BUSW  read data; subordinate i on bits [i*BUSW +: BUSW]
- sub_ack_i  in  NSUB  subordinate acknowledges
- err_adr_o  out  BUSW  address of the most recent errored transaction
- err_cnt_o  out  8  error count, saturates at 255

## Operation
- Decode:
  - Mapped when wbs_adr_i[BUSW-1:BUSW-4]==4'h3 and page p = wbs_adr_i[BUSW-5:4] with 1 ≤ p ≤ NSUB.
  - Target index = p-1.
  - Page 0 and all other addresses are unmapped.
- FSM states: IDLE, FWD, RESP, ERR.
- IDLE, on wbs_cyc_i & wbs_stb_i:
  - Register target index, sub_we_o, sub_adr_o and sub_dat_o.
  - Mapped: go to FWD. Unmapped: go to ERR.
- FWD:
  - sub_stb_o[idx] and sub_cyc_o[idx] are 1; all other bits are 0.
  - Timeout counter clears on entry and increments each FWD cycle without sub_ack_i[idx].
  - sub_ack_i[idx]=1: capture that subordinate's sub_dat_i slice into wbs_dat_o, go to RESP.
  - No ack while counter == TIMEOUT-1: go to ERR (timeout).
  - wbs_cyc_i=0 (host abort): drop the strobes, go to IDLE. No ack, no error, no count.
  - Acks from non-selected subordinates are ignored.
- RESP: wbs_ack_o=1 for one cycle, all sub strobes 0, then IDLE.
- ERR:
  - wbs_err_o=1 for one cycle.
  - err_adr_o is loaded with the registered request address.
  - err_cnt_o increments unless it is already 255.
  - wbs_dat_o is forced to 0.
  - Then IDLE.
- One transaction outstanding at most. Host inputs are ignored outside IDLE, except wbs_cyc_i in FWD.

## Timing
- Reset values (asynchronous assert, synchronous release): FSM=IDLE; every output 0, including wbs_dat_o, err_adr_o and err_cnt_o.
- Reset asserted mid-transaction: strobes, ack and err drop immediately; no response is ever issued for that transaction.
- Latency, with request sampled at edge 0:
  - sub_stb_o is high from cycle 1.
  - Subordinate ack sampled high at the end of cycle k gives wbs_ack_o in cycle k+1.
  - Minimum read latency is 2 cycles (ack in cycle 1 gives host ack in cycle 2).
- Unmapped address: wbs_err_o in cycle 1.
- Timeout: wbs_err_o in cycle TIMEOUT+1.
- Ack in the same cycle the counter reaches TIMEOUT-1: the ack wins (RESP, no error).
- Back-to-back: after RESP/ERR there is always one IDLE cycle. A request still strobed in that IDLE cycle starts a new transaction.
- wbs_dat_o holds its value until the next RESP or ERR.

## Test plan
- Write 0x30000024 data 0x1234 to subordinate 1, which acks in cycle 2:
  - sub_stb_o=3'b010 in cycles 1–2, sub_adr_o=4, sub_we_o=1, sub_dat_o=0x1234.
  - wbs_ack_o in cycle 3 only; err_cnt_o stays 0.
- Read 0x30000010, subordinate 0 returns 0xA5A5A5A5 with ack in cycle 1: wbs_ack_o in cycle 2, wbs_dat_o=0xA5A5A5A5.
- Access 0x30000000 (null page), then 0x40000010:
  - Each gives wbs_err_o in cycle 1 and no sub_stb_o.
  - err_cnt_o=2; err_adr_o=0x40000010.
- Subordinate 2 never acks, TIMEOUT=15:
  - sub_stb_o[2] high in cycles 1–15.
  - wbs_err_o in cycle 16; err_adr_o=0x30000030.
- Subordinate acks exactly in cycle 15, TIMEOUT=15: wbs_ack_o in cycle 16, no wbs_err_o.
- Boundary cases:
  - Host drops wbs_cyc_i in FWD cycle 3: strobes drop next cycle, no ack or err.
  - 260 unmapped accesses leave err_cnt_o=255.
  - wb_rst_ni pulsed low mid-FWD clears every output asynchronously.
